skewed_input_buffer: RTL and testbench

Parametrised, multi-channel input buffer that feeds the west edge of the systolic array. Each channel stores vectors of LANES packed elements in its own FIFO. On a single `start` command, it streams `len` vectors from every channel with a diagonal skew: channel c is delayed c cycles, so operands meet the PE wavefront correctly. It supersedes the fixed 16-channel × 64-bit buffer with independent read enables and adds the stream sequencer, skew, and error flags.

---
 rtl/skewed_input_buffer.sv | 156 +++++++++++++++
 tb/tb_skewed_input_buffer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/skewed_input_buffer.sv
// skewed_input_buffer: per-channel vector FIFOs streamed to the systolic array west edge.
// Define SKEWED_INPUT_BUFFER_SKEW_EN for the diagonal skew S(c)=c; otherwise channels stream in lockstep.
module skewed_input_buffer #(
  parameter int ELEM_W   = 8,
  parameter int LANES    = 8,
  parameter int CHANNELS = 16,
  parameter int DEPTH    = 4,
  parameter int LEN_W    = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [CHANNELS-1:0]               wr_en,
  input  logic [ELEM_W*LANES*CHANNELS-1:0]  din,
  input  logic                              start,
  input  logic [LEN_W-1:0]                  len,
  output logic [ELEM_W*LANES*CHANNELS-1:0]  dout,
  output logic [CHANNELS-1:0]               dout_valid,
  output logic                              busy,
  output logic                              done,
  output logic [CHANNELS-1:0]               empty,
  output logic [CHANNELS-1:0]               full,
  output logic [CHANNELS-1:0]               overflow,
  output logic [CHANNELS-1:0]               underflow
);
  localparam int VW = ELEM_W * LANES;
  localparam int AW = $clog2(DEPTH);
  localparam int KW = LEN_W + $clog2(CHANNELS) + 1;
`ifdef SKEWED_INPUT_BUFFER_SKEW_EN
  localparam int S_LAST = CHANNELS - 1;
`else
  localparam int S_LAST = 0;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, DONE = 2'd2} state_t;

  state_t           state_r, state_next_s;
  logic [KW-1:0]    k_r, k_next_s, k_last_s, len_ext_s;
  logic [LEN_W-1:0] len_r, len_next_s;
  logic             busy_r, done_r, stream_s;

  assign len_ext_s = {{(KW-LEN_W){1'b0}}, len_r};
  assign k_last_s  = KW'(S_LAST) + len_ext_s - KW'(1);
  assign stream_s  = (state_r == STREAM);
  assign busy      = busy_r;
  assign done      = done_r;

  // Stream sequencer next-state: latch len on an accepted start, count k until the last channel's last pop.
  always_comb begin
    state_next_s = state_r;
    k_next_s     = k_r;
    len_next_s   = len_r;
    case (state_r)
      IDLE: begin
        if (start && (len != {LEN_W{1'b0}})) begin
          state_next_s = STREAM;
          k_next_s     = {KW{1'b0}};
          len_next_s   = len;
        end else begin
          state_next_s = IDLE;
        end
      end
      STREAM: begin
        k_next_s = k_r + KW'(1);
        if (k_r == k_last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = STREAM;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Sequencer state register; busy/done are registered from the next state so they line up with data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      k_r     <= {KW{1'b0}};
      len_r   <= {LEN_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      k_r     <= k_next_s;
      len_r   <= len_next_s;
      busy_r  <= (state_next_s != IDLE);
      done_r  <= (state_next_s == DONE);
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [AW:0]   wr_ptr_r, rd_ptr_r;
    logic [VW-1:0] mem_r [DEPTH];
    logic [VW-1:0] dout_r;
    logic          valid_r, ovf_r, udf_r;
    logic          full_s, empty_s, pop_s, push_s;

    assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign push_s  = wr_en[c] && !full_s;

`ifdef SKEWED_INPUT_BUFFER_SKEW_EN
    // Window S(c) <= k < S(c)+L; the extra MSB of rel_s flags k < S(c).
    logic [KW:0] rel_s;
    assign rel_s = {1'b0, k_r} - (KW+1)'(c);
    assign pop_s = stream_s && !rel_s[KW] && (rel_s[KW-1:0] < len_ext_s);
`else
    assign pop_s = stream_s && (k_r < len_ext_s);
`endif

    // Storage array: no reset, contents are discarded by clearing the pointers.
    always_ff @(posedge clk) begin
      if (push_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= din[VW*c +: VW];
      end
    end

    // Pointers, registered read port and sticky error flags; status is taken before this cycle's pop.
    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr_r <= {(AW+1){1'b0}};
        rd_ptr_r <= {(AW+1){1'b0}};
        dout_r   <= {VW{1'b0}};
        valid_r  <= 1'b0;
        ovf_r    <= 1'b0;
        udf_r    <= 1'b0;
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
        end else if (wr_en[c]) begin
          ovf_r <= 1'b1;
        end
        if (pop_s && !empty_s) begin
          rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
          dout_r   <= mem_r[rd_ptr_r[AW-1:0]];
          valid_r  <= 1'b1;
        end else begin
          dout_r  <= {VW{1'b0}};
          valid_r <= 1'b0;
          if (pop_s) begin
            udf_r <= 1'b1;
          end
        end
      end
    end

    assign dout[VW*c +: VW] = dout_r;
    assign dout_valid[c]    = valid_r;
    assign empty[c]         = empty_s;
    assign full[c]          = full_s;
    assign overflow[c]      = ovf_r;
    assign underflow[c]     = udf_r;
  end

endmodule

// File: tb/tb_skewed_input_buffer.sv
// Scoreboard bench for skewed_input_buffer: a queue-based FIFO model schedules timestamped expectations,
// a negedge monitor compares them against the DUT outputs.
module tb_skewed_input_buffer;
  localparam int ELEM_W   = 8;
  localparam int LANES    = 8;
  localparam int CHANNELS = 16;
  localparam int DEPTH    = 4;
  localparam int LEN_W    = 8;
  localparam int VW       = ELEM_W * LANES;
`ifdef SKEWED_INPUT_BUFFER_SKEW_EN
  localparam bit SKEW = 1'b1;
`else
  localparam bit SKEW = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst;
  logic [CHANNELS-1:0]      wr_en;
  logic [VW*CHANNELS-1:0]   din;
  logic                     start;
  logic [LEN_W-1:0]         len;
  logic [VW*CHANNELS-1:0]   dout;
  logic [CHANNELS-1:0]      dout_valid;
  logic                     busy, done;
  logic [CHANNELS-1:0]      empty, full, overflow, underflow;

  skewed_input_buffer #(
    .ELEM_W(ELEM_W), .LANES(LANES), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .start(start), .len(len),
    .dout(dout), .dout_valid(dout_valid), .busy(busy), .done(done),
    .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int            cyc;
    logic          valid;
    logic [VW-1:0] data;
  } exp_t;

  exp_t                exp_q   [CHANNELS][$];
  int                  done_q  [$];
  logic [VW-1:0]       model_q [CHANNELS][$];
  logic [CHANNELS-1:0] ovf_m, udf_m;
  int                  last_done_cyc;
  int                  checks = 0;
  int                  errors = 0;
  int                  cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: pop every expectation that falls due this cycle, flag anything the DUT shows unasked.
  always @(negedge clk) begin
    exp_t e;
    for (int c = 0; c < CHANNELS; c++) begin
      if (exp_q[c].size() > 0 && exp_q[c][0].cyc == cyc) begin
        e = exp_q[c].pop_front();
        check($sformatf("valid_ch%0d", c), VW'(dout_valid[c]), VW'(e.valid));
        check($sformatf("data_ch%0d", c), dout[VW*c +: VW], e.data);
      end else if (dout_valid[c]) begin
        check($sformatf("spurious_valid_ch%0d", c), VW'(dout_valid[c]), VW'(0));
      end
    end
    if (done_q.size() > 0 && done_q[0] == cyc) begin
      void'(done_q.pop_front());
      check("done", VW'(done), VW'(1));
    end else if (done) begin
      check("spurious_done", VW'(done), VW'(0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    logic [CHANNELS-1:0] e_empty, e_full;
    for (int c = 0; c < CHANNELS; c++) begin
      e_empty[c] = (model_q[c].size() == 0);
      e_full[c]  = (model_q[c].size() == DEPTH);
    end
    check({tag, "_empty"}, VW'(empty), VW'(e_empty));
    check({tag, "_full"}, VW'(full), VW'(e_full));
    check({tag, "_overflow"}, VW'(overflow), VW'(ovf_m));
    check({tag, "_underflow"}, VW'(underflow), VW'(udf_m));
    check({tag, "_busy"}, VW'(busy), VW'(cyc <= last_done_cyc));
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_done_cyc = cyc - 1;
    for (int c = 0; c < CHANNELS; c++) begin
      model_q[c].delete();
      exp_q[c].delete();
    end
    done_q.delete();
    ovf_m = '0;
    udf_m = '0;
    check("rst_busy", VW'(busy), VW'(0));
    check("rst_done", VW'(done), VW'(0));
    check("rst_valid", VW'(dout_valid), VW'(0));
    check("rst_dout", dout[VW-1:0], VW'(0));
    check_status("rst");
  endtask

  task automatic write_cycle(input logic [CHANNELS-1:0] mask, input logic [VW*CHANNELS-1:0] data);
    wr_en = mask;
    din   = data;
    for (int c = 0; c < CHANNELS; c++) begin
      if (mask[c]) begin
        if (model_q[c].size() < DEPTH) model_q[c].push_back(data[VW*c +: VW]);
        else ovf_m[c] = 1'b1;
      end
    end
    tick();
    wr_en = '0;
  endtask

  // Issue a start; if the sequencer is idle and len is nonzero, schedule every pop and the done pulse.
  task automatic do_start(input int l);
    int   t;
    int   s;
    exp_t e;
    t = cyc;
    start = 1'b1;
    len = LEN_W'(l);
    if (l != 0 && cyc > last_done_cyc) begin
      for (int c = 0; c < CHANNELS; c++) begin
        s = SKEW ? c : 0;
        for (int i = 0; i < l; i++) begin
          e.cyc = t + 2 + s + i;
          if (model_q[c].size() > 0) begin
            e.valid = 1'b1;
            e.data  = model_q[c].pop_front();
          end else begin
            e.valid = 1'b0;
            e.data  = '0;
            udf_m[c] = 1'b1;
          end
          exp_q[c].push_back(e);
        end
      end
      last_done_cyc = t + 1 + (SKEW ? CHANNELS - 1 : 0) + l;
      done_q.push_back(last_done_cyc);
    end
    tick();
    start = 1'b0;
    check("busy_after_start", VW'(busy), VW'(cyc <= last_done_cyc));
  endtask

  task automatic wait_idle(input bit noisy);
    int n = 0;
    while (cyc <= last_done_cyc && n < 300) begin
      if (noisy && $urandom_range(0, 3) == 0) do_start($urandom_range(0, 5));
      else tick();
      n++;
    end
    check("wait_idle_bound", VW'(n < 300), VW'(1));
  endtask

  function automatic logic [VW*CHANNELS-1:0] pattern(input int n);
    logic [VW*CHANNELS-1:0] d;
    for (int c = 0; c < CHANNELS; c++) d[VW*c +: VW] = VW'(c * 16 + n);
    return d;
  endfunction

  function automatic logic [VW*CHANNELS-1:0] rand_data();
    logic [VW*CHANNELS-1:0] d;
    for (int c = 0; c < CHANNELS; c++) d[VW*c +: VW] = {$urandom, $urandom};
    return d;
  endfunction

  initial begin
    rst = 1'b1; wr_en = '0; din = '0; start = 1'b0; len = '0;
    last_done_cyc = -1;
    repeat (2) tick();
    reset_dut();

    // Three vectors per channel, then a len=3 stream.
    for (int n = 0; n < 3; n++) write_cycle('1, pattern(n));
    check_status("s1_loaded");
    do_start(3);
    wait_idle(1'b0);
    check_status("s1_end");

    // Overflow on channel 2.
    reset_dut();
    for (int n = 0; n < 4; n++) write_cycle(CHANNELS'(1) << 2, pattern(n));
    check_status("s3_four");
    write_cycle(CHANNELS'(1) << 2, pattern(4));
    check_status("s3_five");
    do_start(4);
    wait_idle(1'b0);
    check_status("s3_end");

    // Underflow on channel 5 only.
    reset_dut();
    write_cycle('1, pattern(0));
    write_cycle(~(CHANNELS'(1) << 5), pattern(1));
    do_start(2);
    wait_idle(1'b0);
    check_status("s4_end");

    // Ignored starts: len=0 while idle, then starts while busy.
    write_cycle('1, pattern(7));
    do_start(0);
    do_start(3);
    tick();
    do_start(5);
    do_start(2);
    wait_idle(1'b0);
    check_status("s5_end");

    // Reset in cycle T+4 of a len=3 stream.
    reset_dut();
    for (int n = 0; n < 3; n++) write_cycle('1, pattern(n));
    do_start(3);
    repeat (3) tick();
    reset_dut();
    tick();
    check("post_rst_done", VW'(done), VW'(0));

    // Randomised streams with noisy starts while busy.
    for (int it = 0; it < 25; it++) begin
      if (it % 8 == 7) reset_dut();
      repeat ($urandom_range(0, 5)) write_cycle(CHANNELS'($urandom), rand_data());
      do_start($urandom_range(0, 6));
      wait_idle(1'b1);
      check_status("rnd");
    end

    repeat (3) tick();
    for (int c = 0; c < CHANNELS; c++) check("leftover_exp", VW'(exp_q[c].size()), VW'(0));
    check("leftover_done", VW'(done_q.size()), VW'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
